key_intr_gen: RTL and testbench
===============================

KEY_INTR_GEN -- requirements
Module: key_intr_gen

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 2500000, meaning the number of consecutive synchronized samples required to accept a key level change (20 ms at 125 MHz); the legal range SHALL be 2 to 2^24-1.
REQ-002 The block SHALL have parameter PULSE_CYCLES, default 8, meaning the width of the intr pulse in clk cycles; the legal range SHALL be 1 to DEBOUNCE_CYCLES.
REQ-003 The block SHALL have parameter KEY_ACTIVE_LOW, default 1, where 1 means key pressed = 0.
REQ-004 Port clk, input, 1 bit: the single clock (CLK_125M domain); all logic SHALL be clocked on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 Port key, input, 2 bits: raw asynchronous push-button inputs, one per channel.
REQ-007 Port intr, output, 2 bits: per-channel press-interrupt pulse; drives the processor PIO interrupt input.
REQ-008 Port key_state, output, 2 bits: per-channel debounced pressed level, where 1 = pressed.

Function
REQ-009 Each key bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 The synchronized value SHALL be normalized to pressed = KEY_ACTIVE_LOW ? ~sync : sync.
REQ-011 Channels 0 and 1 SHALL be fully independent copies: FSM, debounce counter (width clog2(DEBOUNCE_CYCLES)), and pulse counter.
REQ-012 FSM states SHALL be IDLE, PRESS_DB, HELD and RELEASE_DB.
REQ-013 IDLE: if pressed, go to PRESS_DB with cnt=1; else hold with cnt=0.
REQ-014 PRESS_DB: if not pressed, go to IDLE with cnt=0; if pressed and cnt==DEBOUNCE_CYCLES-1, go to HELD with cnt=0; if pressed otherwise, cnt+1.
REQ-015 HELD: if not pressed, go to RELEASE_DB with cnt=1; else hold.
REQ-016 RELEASE_DB: if pressed, go to HELD with cnt=0; if not pressed and cnt==DEBOUNCE_CYCLES-1, go to IDLE with cnt=0; if not pressed otherwise, cnt+1.
REQ-017 key_state[i] SHALL be registered and equal 1 exactly while the channel FSM is in HELD or RELEASE_DB.
REQ-018 The PRESS_DB->HELD transition SHALL be the only press event; release and bounce SHALL generate no event.
REQ-019 A press event SHALL set intr[i]=1 at the same clock edge the FSM enters HELD, and intr[i] SHALL remain high for exactly PULSE_CYCLES cycles.
REQ-020 A new press event while intr[i] is high SHALL reload the pulse to a full PULSE_CYCLES, with no low gap.
REQ-021 Latency: a raw key first sampled pressed at edge 1 and held stable SHALL produce intr rising at edge 2+DEBOUNCE_CYCLES.
REQ-022 Any pressed-level sample shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no intr and no key_state change.
REQ-023 Debounce counters SHALL never wrap; the terminal compare SHALL occur before overflow for every legal DEBOUNCE_CYCLES.
REQ-024 Simultaneous press events on both channels SHALL assert both intr bits in the same cycle.
REQ-025 All outputs SHALL be registered, with no combinational path from key to intr or key_state.

Reset
REQ-026 When rst_n==0 at a clock edge, that edge SHALL set: synchronizer flops to the released level, FSM=IDLE, all counters 0, intr=2'b00, key_state=2'b00.
REQ-027 Reset asserted mid-pulse or mid-debounce SHALL drop intr and key_state at that edge, with no resumed pulse after release.
REQ-028 A key held through reset release SHALL be debounced afresh, and intr SHALL rise at edge 2+DEBOUNCE_CYCLES after the first edge with rst_n==1.

Verification
REQ-029 With DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, a clean press on key[0] held 20 cycles -> intr=2'b01 at edges 6..8 and 2'b00 afterwards; key_state[0]=1 from edge 6.
REQ-030 Bounce of key[1] pressed for 3 cycles, released for 1, then pressed steadily -> no intr from the 3-cycle glitch; a single 3-cycle intr[1] pulse once 4 stable samples are seen.
REQ-031 Release of a held key with 2-cycle re-press chatter -> key_state stays 1 through the chatter, falls 4 stable released samples later, and intr stays 0.
REQ-032 Both keys pressed on the same edge -> intr=2'b11 for 3 cycles beginning at edge 6.
REQ-033 rst_n pulled low during the second pulse cycle -> intr=2'b00 at that edge; a key kept pressed yields a fresh pulse at edge 6 after reset release.
REQ-034 With KEY_ACTIVE_LOW=0, the polarity of scenario REQ-029 inverted -> identical intr and key_state timing.

Source files
------------

// File: rtl/key_intr_gen.sv
// Two-channel push-button debouncer with press-interrupt pulse generation.
// Each channel: 2-flop synchronizer, 4-state debounce FSM, and a reloadable pulse stretcher.
module key_intr_gen #(
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int PULSE_CYCLES    = 8,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key,
    output logic [1:0] intr,
    output logic [1:0] key_state
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (PULSE_CYCLES > 2) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);
    localparam logic [1:0]    KEY_RELEASED = (KEY_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = key;
        sync2_d = sync1_q;
    end

    // Synchronizers reset to the released level so a held key is debounced afresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= KEY_RELEASED;
            sync2_q <= KEY_RELEASED;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            state_t          state_q, state_d;
            logic [CW-1:0]   cnt_q, cnt_d;
            logic [PW-1:0]   pcnt_q, pcnt_d;
            logic            intr_q, intr_d;
            logic            ks_q, ks_d;
            logic            pressed;
            logic            press_evt;

            assign pressed = (KEY_ACTIVE_LOW != 0) ? ~sync2_q[gi] : sync2_q[gi];

            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                press_evt = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (pressed) begin
                            state_d = PRESS_DB;
                            cnt_d   = CW'(1);
                        end else begin
                            cnt_d   = '0;
                        end
                    end
                    PRESS_DB: begin
                        if (!pressed) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d   = HELD;
                            cnt_d     = '0;
                            press_evt = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!pressed) begin
                            state_d = RELEASE_DB;
                            cnt_d   = CW'(1);
                        end
                    end
                    RELEASE_DB: begin
                        if (pressed) begin
                            state_d = HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            // pcnt holds the remaining high cycles after the current one; a new event reloads it.
            always_comb begin
                intr_d = intr_q;
                pcnt_d = pcnt_q;
                if (press_evt) begin
                    intr_d = 1'b1;
                    pcnt_d = PULSE_LOAD;
                end else if (intr_q) begin
                    if (pcnt_q == '0) begin
                        intr_d = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q - 1'b1;
                    end
                end
                ks_d = (state_d == HELD) || (state_d == RELEASE_DB);
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    pcnt_q  <= '0;
                    intr_q  <= 1'b0;
                    ks_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    pcnt_q  <= pcnt_d;
                    intr_q  <= intr_d;
                    ks_q    <= ks_d;
                end
            end

            assign intr[gi]      = intr_q;
            assign key_state[gi] = ks_q;
        end
    endgenerate

endmodule

// File: tb/tb_key_intr_gen.sv
// Directed bench for key_intr_gen with DEBOUNCE_CYCLES=4, PULSE_CYCLES=3.
// An active-high instance is fed the inverted keys and must match the same timing.
module tb_key_intr_gen;

    logic       clk;
    logic       rst_n;
    logic [1:0] key;
    logic [1:0] key_ah;
    logic [1:0] intr, intr_ah;
    logic [1:0] key_state, key_state_ah;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_intr;
    logic [1:0] exp_ks;

    assign key_ah = ~key;

    key_intr_gen #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .KEY_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .intr(intr), .key_state(key_state)
    );

    key_intr_gen #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .KEY_ACTIVE_LOW(0)) dut_ah (
        .clk(clk), .rst_n(rst_n), .key(key_ah), .intr(intr_ah), .key_state(key_state_ah)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raw key level: active-low, so 2'b11 means nothing pressed.
    task automatic idle_keys(input int n);
        key = 2'b11;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key   = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            if (e == 3) key = 2'b00;
            n_checks++;
            if (intr !== 2'b00) begin n_fail++; $display("FAIL reset intr edge %0d: got %b want 00", e, intr); end
            n_checks++;
            if (key_state !== 2'b00) begin n_fail++; $display("FAIL reset key_state edge %0d: got %b want 00", e, key_state); end
            n_checks++;
            if (intr_ah !== 2'b00 || key_state_ah !== 2'b00) begin
                n_fail++; $display("FAIL reset_ah edge %0d: got intr %b ks %b want 00 00", e, intr_ah, key_state_ah);
            end
        end
        key   = 2'b11;
        rst_n = 1'b1;
        idle_keys(10);
    endtask

    task automatic test_clean_press();
        key = 2'b10;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            exp_intr = (e >= 6 && e <= 8) ? 2'b01 : 2'b00;
            exp_ks   = (e >= 6) ? 2'b01 : 2'b00;
            n_checks++;
            if (intr !== exp_intr) begin n_fail++; $display("FAIL clean_press intr edge %0d: got %b want %b", e, intr, exp_intr); end
            n_checks++;
            if (key_state !== exp_ks) begin n_fail++; $display("FAIL clean_press key_state edge %0d: got %b want %b", e, key_state, exp_ks); end
            n_checks++;
            if (intr_ah !== exp_intr) begin n_fail++; $display("FAIL clean_press_ah intr edge %0d: got %b want %b", e, intr_ah, exp_intr); end
            n_checks++;
            if (key_state_ah !== exp_ks) begin n_fail++; $display("FAIL clean_press_ah key_state edge %0d: got %b want %b", e, key_state_ah, exp_ks); end
        end
        // Release: stable released samples from edge 1 drop key_state at edge 6.
        key = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            exp_ks = (e < 6) ? 2'b01 : 2'b00;
            n_checks++;
            if (key_state !== exp_ks || intr !== 2'b00) begin
                n_fail++; $display("FAIL clean_release edge %0d: got ks %b intr %b want ks %b intr 00", e, key_state, intr, exp_ks);
            end
            n_checks++;
            if (key_state_ah !== exp_ks || intr_ah !== 2'b00) begin
                n_fail++; $display("FAIL clean_release_ah edge %0d: got ks %b intr %b want ks %b intr 00", e, key_state_ah, intr_ah, exp_ks);
            end
        end
        idle_keys(4);
    endtask

    task automatic test_bounce_press();
        for (int e = 1; e <= 20; e++) begin
            // Raw key[1] pressed at edges 1..3, released at 4, pressed from 5.
            key = (e == 4) ? 2'b11 : 2'b01;
            @(posedge clk); #1;
            exp_intr = (e >= 10 && e <= 12) ? 2'b10 : 2'b00;
            exp_ks   = (e >= 10) ? 2'b10 : 2'b00;
            n_checks++;
            if (intr !== exp_intr) begin n_fail++; $display("FAIL bounce_press intr edge %0d: got %b want %b", e, intr, exp_intr); end
            n_checks++;
            if (key_state !== exp_ks) begin n_fail++; $display("FAIL bounce_press key_state edge %0d: got %b want %b", e, key_state, exp_ks); end
            n_checks++;
            if (intr_ah !== exp_intr || key_state_ah !== exp_ks) begin
                n_fail++; $display("FAIL bounce_press_ah edge %0d: got intr %b ks %b want %b %b", e, intr_ah, key_state_ah, exp_intr, exp_ks);
            end
        end
        idle_keys(12);
    endtask

    task automatic test_release_chatter();
        key = 2'b10;
        repeat (14) @(posedge clk);
        #1;
        n_checks++;
        if (key_state !== 2'b01 || intr !== 2'b00) begin
            n_fail++; $display("FAIL chatter_setup: got ks %b intr %b want ks 01 intr 00", key_state, intr);
        end
        for (int e = 1; e <= 14; e++) begin
            // Released at edge 1, re-pressed at 2..3, released steadily from 4.
            key = (e == 2 || e == 3) ? 2'b10 : 2'b11;
            @(posedge clk); #1;
            exp_ks = (e < 9) ? 2'b01 : 2'b00;
            n_checks++;
            if (key_state !== exp_ks) begin n_fail++; $display("FAIL release_chatter key_state edge %0d: got %b want %b", e, key_state, exp_ks); end
            n_checks++;
            if (intr !== 2'b00) begin n_fail++; $display("FAIL release_chatter intr edge %0d: got %b want 00", e, intr); end
            n_checks++;
            if (intr_ah !== 2'b00 || key_state_ah !== exp_ks) begin
                n_fail++; $display("FAIL release_chatter_ah edge %0d: got intr %b ks %b want 00 %b", e, intr_ah, key_state_ah, exp_ks);
            end
        end
        idle_keys(4);
    endtask

    task automatic test_both_keys();
        key = 2'b00;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            exp_intr = (e >= 6 && e <= 8) ? 2'b11 : 2'b00;
            exp_ks   = (e >= 6) ? 2'b11 : 2'b00;
            n_checks++;
            if (intr !== exp_intr) begin n_fail++; $display("FAIL both_keys intr edge %0d: got %b want %b", e, intr, exp_intr); end
            n_checks++;
            if (key_state !== exp_ks) begin n_fail++; $display("FAIL both_keys key_state edge %0d: got %b want %b", e, key_state, exp_ks); end
            n_checks++;
            if (intr_ah !== exp_intr || key_state_ah !== exp_ks) begin
                n_fail++; $display("FAIL both_keys_ah edge %0d: got intr %b ks %b want %b %b", e, intr_ah, key_state_ah, exp_intr, exp_ks);
            end
        end
        idle_keys(12);
    endtask

    task automatic test_reset_mid_pulse();
        key = 2'b10;
        for (int e = 1; e <= 7; e++) begin
            if (e == 7) rst_n = 1'b0;
            @(posedge clk); #1;
            exp_intr = (e == 6) ? 2'b01 : 2'b00;
            exp_ks   = (e == 6) ? 2'b01 : 2'b00;
            n_checks++;
            if (intr !== exp_intr || key_state !== exp_ks) begin
                n_fail++; $display("FAIL reset_mid_pulse edge %0d: got intr %b ks %b want %b %b", e, intr, key_state, exp_intr, exp_ks);
            end
            n_checks++;
            if (intr_ah !== exp_intr || key_state_ah !== exp_ks) begin
                n_fail++; $display("FAIL reset_mid_pulse_ah edge %0d: got intr %b ks %b want %b %b", e, intr_ah, key_state_ah, exp_intr, exp_ks);
            end
        end
        rst_n = 1'b1;
        // Edge 1 here is the first edge sampled with rst_n high; key still pressed.
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            exp_intr = (e >= 6 && e <= 8) ? 2'b01 : 2'b00;
            exp_ks   = (e >= 6) ? 2'b01 : 2'b00;
            n_checks++;
            if (intr !== exp_intr) begin n_fail++; $display("FAIL after_reset intr edge %0d: got %b want %b", e, intr, exp_intr); end
            n_checks++;
            if (key_state !== exp_ks) begin n_fail++; $display("FAIL after_reset key_state edge %0d: got %b want %b", e, key_state, exp_ks); end
            n_checks++;
            if (intr_ah !== exp_intr || key_state_ah !== exp_ks) begin
                n_fail++; $display("FAIL after_reset_ah edge %0d: got intr %b ks %b want %b %b", e, intr_ah, key_state_ah, exp_intr, exp_ks);
            end
        end
        idle_keys(12);
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 2'b11;
        test_reset();
        test_clean_press();
        test_bounce_press();
        test_release_chatter();
        test_both_keys();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
